// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage: address width,
// redirect source encodings, NOP word and the run/halt state type.
`ifndef ADDRWIDTH
`define ADDRWIDTH 7
`endif

package instruction_fetch_pkg;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_ADDR_DEF = `ADDRWIDTH;

  localparam int unsigned NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_REG    = 2'b11
  } pc_src_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Control, redirect, program-load and IF/ID output bundle of the fetch stage.
interface instruction_fetch_if
  import instruction_fetch_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
);
  logic               i_enable;
  logic               i_pc_write;
  logic               i_IF_ID_write;
  logic               i_branch_or_jump;
  logic [1:0]         i_pc_src;
  logic [NB_ADDR-1:0] i_addr_branch;
  logic [NB_ADDR-1:0] i_addr_jump;
  logic [NB_ADDR-1:0] i_addr_register;
  logic               i_halt;
  logic               i_mem_wr_en;
  logic [NB_ADDR-1:0] i_mem_wr_addr;
  logic [NB_DATA-1:0] i_mem_wr_data;
  logic [NB_DATA-1:0] o_instruction;
  logic [NB_ADDR-1:0] o_pc;
  logic [NB_ADDR-1:0] o_pc_debug;
  logic               o_halted;

  modport master (
    output i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
           i_addr_branch, i_addr_jump, i_addr_register, i_halt,
           i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
    input  o_instruction, o_pc, o_pc_debug, o_halted
  );

  modport slave (
    input  i_enable, i_pc_write, i_IF_ID_write, i_branch_or_jump, i_pc_src,
           i_addr_branch, i_addr_jump, i_addr_register, i_halt,
           i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
    output o_instruction, o_pc, o_pc_debug, o_halted
  );
endinterface

// File: rtl/instruction_memory.sv
// Program memory: synchronous write, combinational read. Not reset, so a
// loaded program survives a core reset.
module instruction_memory
  import instruction_fetch_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clock,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);
  localparam int DEPTH = 1 << NB_ADDR;

  logic [NB_DATA-1:0] mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
  end

  // A write to the address being read shows up only after the edge, so the
  // fetch latch sees the old word in the same cycle.
  assign o_rd_data = mem[i_rd_addr];
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register with redirect/stall, IF/ID latch with flush,
// sticky halt and the program memory instance.
//   state     | meaning
//   ST_RUN    | PC and IF/ID may advance under enable and hazard permits
//   ST_HALTED | HALT seen; all fetch state frozen until reset
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input logic                 i_clock,
  input logic                 i_reset,
  instruction_fetch_if.slave  bus
);
  fetch_state_t       state;
  logic [NB_ADDR-1:0] pc;
  logic [NB_ADDR-1:0] pc_inc;
  logic [NB_ADDR-1:0] next_pc;
  logic [NB_DATA-1:0] if_instr;
  logic [NB_ADDR-1:0] if_pc;
  logic [NB_DATA-1:0] mem_word;
  logic               running;
  logic               halt_now;
  logic               advance;
  logic               ifid_update;
  logic               redirect;

  instruction_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .i_clock   (i_clock),
    .i_wr_en   (bus.i_mem_wr_en & ~i_reset),
    .i_wr_addr (bus.i_mem_wr_addr),
    .i_wr_data (bus.i_mem_wr_data),
    .i_rd_addr (pc),
    .o_rd_data (mem_word)
  );

  assign running  = (state == ST_RUN);
  assign halt_now = bus.i_enable & bus.i_halt & running;
  // A stalled PC means the decode-stage redirect is not yet committed.
  assign redirect    = bus.i_branch_or_jump & bus.i_pc_write;
  assign advance     = bus.i_enable & bus.i_pc_write & running & ~bus.i_halt;
  assign ifid_update = bus.i_enable & bus.i_IF_ID_write & running & ~bus.i_halt;
  assign pc_inc      = pc + NB_ADDR'(1);

  always_comb begin
    next_pc = pc_inc;
    if (bus.i_branch_or_jump) begin
      case (pc_src_t'(bus.i_pc_src))
        PC_SRC_BRANCH: next_pc = bus.i_addr_branch;
        PC_SRC_JUMP:   next_pc = bus.i_addr_jump;
        PC_SRC_REG:    next_pc = bus.i_addr_register;
        default:       next_pc = pc_inc;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_RUN;
      pc       <= '0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (halt_now) begin
      state <= ST_HALTED;
    end else begin
      if (advance) pc <= next_pc;
      if (ifid_update) begin
        if (redirect) begin
          if_instr <= NB_DATA'(NOP_WORD);
          if_pc    <= '0;
        end else begin
          if_instr <= mem_word;
          if_pc    <= pc_inc;
        end
      end
    end
  end

  assign bus.o_instruction = if_instr;
  assign bus.o_pc          = if_pc;
  assign bus.o_pc_debug    = pc;
  assign bus.o_halted      = (state == ST_HALTED);
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter NB_DATA, default 32, instruction word width.
REQ-002 Parameter NB_ADDR, default `ADDRWIDTH (7), word address width; memory depth 2^NB_ADDR words.
REQ-003 i_clock  in  1  clock; all state updates on rising edge.
REQ-004 i_reset  in  1  reset, synchronous, active-high.
REQ-005 i_enable  in  1  run/step enable from debug unit; 0 freezes all pipeline state.
REQ-006 i_pc_write  in  1  PC update permit from hazard unit; 0 = stall.
REQ-007 i_IF_ID_write  in  1  IF/ID latch update permit from hazard unit.
REQ-008 i_branch_or_jump  in  1  taken branch/jump resolved in decode.
REQ-009 i_pc_src  in  2  redirect source: 01 branch, 10 jump, 11 register, 00 sequential.
REQ-010 i_addr_branch, i_addr_jump, i_addr_register  in  NB_ADDR each  redirect targets.
REQ-011 i_halt  in  1  HALT detected in decode.
REQ-012 i_mem_wr_en  in  1; i_mem_wr_addr  in  NB_ADDR; i_mem_wr_data  in  NB_DATA  program load port.
REQ-013 o_instruction  out  NB_DATA  IF/ID instruction.
REQ-014 o_pc  out  NB_ADDR  IF/ID PC+1 of latched instruction.
REQ-015 o_pc_debug  out  NB_ADDR  current PC register.
REQ-016 o_halted  out  1  sticky halt flag.

Function
REQ-017 Internal advance = i_enable & i_pc_write & !halted.
REQ-018 On advance with i_branch_or_jump=1, PC <= target selected by i_pc_src; with i_pc_src=00 PC <= PC+1.
REQ-019 On advance with i_branch_or_jump=0, PC <= PC+1, modulo 2^NB_ADDR (2^NB_ADDR-1 wraps to 0).
REQ-020 Instruction memory read is combinational at PC; write is synchronous on i_mem_wr_en, independent of i_enable and halt.
REQ-021 Read-during-write to the PC address in the same cycle: IF/ID captures the old word; new word visible the following cycle.
REQ-022 IF/ID update = i_enable & i_IF_ID_write & !halted; otherwise o_instruction and o_pc hold.
REQ-023 On IF/ID update with i_pc_write=1 and i_branch_or_jump=1, latch flushes: o_instruction <= 0 (NOP), o_pc <= 0; no delay slot.
REQ-024 On IF/ID update otherwise, o_instruction <= mem[PC], o_pc <= PC+1 (wrapped).
REQ-025 i_branch_or_jump is ignored (no redirect, no flush) while i_pc_write=0.
REQ-026 i_halt with i_enable=1 sets halted at the edge; that edge PC and IF/ID hold; halt has priority over redirect and flush.
REQ-027 halted clears only on reset; o_halted = halted; fetch latency = 1 cycle from PC to IF/ID.

Reset
REQ-028 Reset, synchronous: PC=0, o_instruction=0, o_pc=0, o_halted=0; o_pc_debug=0.
REQ-029 Reset has priority over enable, halt, redirect and memory write; memory contents are not cleared.
REQ-030 Reset mid-stall or mid-flush yields the REQ-028 state on the next edge.

Structure
REQ-031 Shared header holds NB_ADDR (`ADDRWIDTH), PC_SRC encodings (SEQ/BRANCH/JUMP/REG) and NOP word constant.
REQ-032 Memory is a sub-module instruction_memory (sync write, async read); PC logic and IF/ID latch are in instruction_fetch.

Verification
REQ-033 Load mem[0..3]=0x11,0x22,0x33,0x44, reset, enable -> o_instruction 0x11,0x22,0x33 on successive cycles, o_pc 1,2,3.
REQ-034 PC=5, i_branch_or_jump=1, i_pc_src=01, i_addr_branch=0x20 -> next cycle o_instruction=0, o_pc=0, o_pc_debug=0x20; following cycle mem[0x20].
REQ-035 i_pc_write=0, i_IF_ID_write=0, i_branch_or_jump=1 for 2 cycles at PC=3 -> PC stays 3, IF/ID holds, no flush.
REQ-036 PC=0x7F, no redirect -> PC=0x00, o_pc=0x00.
REQ-037 i_halt=1 at PC=9 with i_pc_src=10 taken -> PC stays 9, o_halted=1 until reset; reset -> PC=0, o_halted=0.
REQ-038 i_mem_wr_en writes 0xABCD to current PC -> IF/ID captures old word that edge; i_enable=0 for 3 cycles freezes all outputs.
